// File: rtl/mem_port_arbiter_if.sv
// Purpose: groups the fetch, data and memory handshakes of the unified memory port arbiter.
// Ports: fetch req/resp (if_*), data req/resp (d_*), memory req/resp (m_*).
// Modports: master = core + memory side, slave = arbiter side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch channel
    logic                  if_req_valid;
    logic [ADDR_W-1:0]     if_req_addr;
    logic                  if_req_ready;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_rvalid;
    logic                  if_rready;

    // Data (load/store) channel
    logic                  d_req_read;
    logic                  d_req_write;
    logic [ADDR_W-1:0]     d_req_addr;
    logic [DATA_W-1:0]     d_req_wdata;
    logic [DATA_W/8-1:0]   d_req_wstrb;
    logic                  d_req_ready;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_rvalid;
    logic                  d_rready;

    // Unified memory port
    logic                  m_req_valid;
    logic                  m_req_write;
    logic [ADDR_W-1:0]     m_req_addr;
    logic [DATA_W-1:0]     m_req_wdata;
    logic [DATA_W/8-1:0]   m_req_wstrb;
    logic                  m_req_ready;
    logic [DATA_W-1:0]     m_rdata;
    logic                  m_rvalid;
    logic                  m_rready;

    modport master (
        output if_req_valid, if_req_addr, if_rready,
        input  if_req_ready, if_rdata, if_rvalid,
        output d_req_read, d_req_write, d_req_addr, d_req_wdata, d_req_wstrb, d_rready,
        input  d_req_ready, d_rdata, d_rvalid,
        input  m_req_valid, m_req_write, m_req_addr, m_req_wdata, m_req_wstrb, m_rready,
        output m_req_ready, m_rdata, m_rvalid
    );

    modport slave (
        input  if_req_valid, if_req_addr, if_rready,
        output if_req_ready, if_rdata, if_rvalid,
        input  d_req_read, d_req_write, d_req_addr, d_req_wdata, d_req_wstrb, d_rready,
        output d_req_ready, d_rdata, d_rvalid,
        output m_req_valid, m_req_write, m_req_addr, m_req_wdata, m_req_wstrb, m_rready,
        input  m_req_ready, m_rdata, m_rvalid
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between fetch and data channels, round-robin on contention.
// Latency: grant combinational in IDLE, m_req_valid next cycle; read >= 3 cycles, write >= 2.
// Backpressure: request held stable until m_req_ready; m_rready follows the owner's rready.
// Ports: clk, rst (async active-low), bus (slave modport), grant_cnt_if / grant_cnt_d counters.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus,
    output logic [31:0]          grant_cnt_if,
    output logic [31:0]          grant_cnt_d
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    state_t              state_q, state_nxt;
    logic                owner_q;
    logic                last_q;
    logic                lat_write_q;
    logic [ADDR_W-1:0]   lat_addr_q;
    logic [DATA_W-1:0]   lat_wdata_q;
    logic [STRB_W-1:0]   lat_wstrb_q;
    logic [31:0]         cnt_if_q;
    logic [31:0]         cnt_d_q;

    logic                d_req;
    logic                grant_if;
    logic                grant_d;
    logic                m_rready_int;

    always_comb begin
        d_req        = bus.d_req_read | bus.d_req_write;
        grant_if     = 1'b0;
        grant_d      = 1'b0;
        m_rready_int = 1'b0;
        state_nxt    = state_q;

        bus.if_req_ready = 1'b0;
        bus.d_req_ready  = 1'b0;
        bus.if_rvalid    = 1'b0;
        bus.if_rdata     = '0;
        bus.d_rvalid     = 1'b0;
        bus.d_rdata      = '0;
        bus.m_req_valid  = 1'b0;
        bus.m_req_write  = lat_write_q;
        bus.m_req_addr   = lat_addr_q;
        bus.m_req_wdata  = lat_wdata_q;
        bus.m_req_wstrb  = lat_wstrb_q;
        bus.m_rready     = 1'b0;

        case (state_q)
            IDLE: begin
                // On contention the channel that did not win last time goes first.
                grant_if = bus.if_req_valid && (!d_req || last_q == OWN_D);
                grant_d  = d_req && (!bus.if_req_valid || last_q == OWN_IF);
                bus.if_req_ready = grant_if;
                bus.d_req_ready  = grant_d;
                if (grant_if || grant_d) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                bus.m_req_valid = 1'b1;
                if (bus.m_req_ready) begin
                    state_nxt = lat_write_q ? IDLE : RESP;
                end
            end
            RESP: begin
                // Response forwarded straight through; only the owner sees it.
                m_rready_int = (owner_q == OWN_D) ? bus.d_rready : bus.if_rready;
                bus.m_rready = m_rready_int;
                if (owner_q == OWN_D) begin
                    bus.d_rvalid = bus.m_rvalid;
                    bus.d_rdata  = bus.m_rdata;
                end else begin
                    bus.if_rvalid = bus.m_rvalid;
                    bus.if_rdata  = bus.m_rdata;
                end
                if (bus.m_rvalid && m_rready_int) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q     <= OWN_IF;
            last_q      <= OWN_D;
            lat_write_q <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_wstrb_q <= '0;
            cnt_if_q    <= '0;
            cnt_d_q     <= '0;
        end else if (grant_if) begin
            owner_q     <= OWN_IF;
            last_q      <= OWN_IF;
            lat_write_q <= 1'b0;
            lat_addr_q  <= bus.if_req_addr;
            lat_wdata_q <= '0;
            lat_wstrb_q <= '0;
            cnt_if_q    <= cnt_if_q + 32'd1;
        end else if (grant_d) begin
            // Read and write both set is taken as a write; strobes are zero on reads.
            owner_q     <= OWN_D;
            last_q      <= OWN_D;
            lat_write_q <= bus.d_req_write;
            lat_addr_q  <= bus.d_req_addr;
            lat_wdata_q <= bus.d_req_wdata;
            lat_wstrb_q <= bus.d_req_write ? bus.d_req_wstrb : '0;
            cnt_d_q     <= cnt_d_q + 32'd1;
        end
    end

    assign grant_cnt_if = cnt_if_q;
    assign grant_cnt_d  = cnt_d_q;

endmodule
